// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-memory load/store initiator and the data memory.
package load_store_unit_pkg;

  localparam int MEM_DEPTH_DEF = 33;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_NOP = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_addr_gen.sv
// Word-address generation: base + sign-extended offset, with an unsigned range check.
module lsu_addr_gen
  import load_store_unit_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic        [31:0] base,
  input  logic signed [15:0] offset,
  output logic        [31:0] addr,
  output logic               out_of_range
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  always_comb begin
    addr         = base + {{16{offset[15]}}, offset};
    out_of_range = (addr >= DEPTH);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one LW/SW per transaction, a single registered memory access
// window, then a one-cycle response pulse to writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic        [5:0]  req_opcode,
  input  logic        [31:0] req_base,
  input  logic signed [15:0] req_offset,
  input  logic        [31:0] req_rt_data,
  input  logic        [4:0]  req_rt_idx,
  output logic        [5:0]  mem_opcode,
  output logic        [31:0] mem_addr,
  output logic        [31:0] mem_wdata,
  input  logic        [31:0] mem_rdata,
  output logic               resp_valid,
  output logic        [31:0] resp_data,
  output logic        [4:0]  resp_rt_idx,
  output logic               resp_is_load,
  output logic               fault
);

  lsu_state_e  state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_calc;
  logic        addr_oor;
  logic        supported;

  lsu_addr_gen #(.MEM_DEPTH(MEM_DEPTH)) u_addr_gen (
    .base         (req_base),
    .offset       (req_offset),
    .addr         (addr_calc),
    .out_of_range (addr_oor)
  );

  assign supported = is_mem_op(req_opcode);
  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      mem_opcode   <= OP_NOP;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_rt_idx  <= '0;
      resp_is_load <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            resp_rt_idx  <= req_rt_idx;
            resp_is_load <= (req_opcode == OP_LW);
            resp_data    <= '0;
            // Faulting requests never reach the memory port.
            if (!supported || addr_oor) begin
              fault      <= 1'b1;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              fault      <= 1'b0;
              mem_opcode <= req_opcode;
              mem_addr   <= addr_calc;
              mem_wdata  <= req_rt_data;
              wait_cnt   <= 4'(WAIT_CYCLES);
              state      <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (resp_is_load) resp_data <= mem_rdata;
            mem_opcode <= OP_NOP;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (no wait states / 3 wait states)
// in front of simple behavioural data memories.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rt;
    logic        is_load;
    logic        fault;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic        req_ready, req_ready2;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_base = '0;
  logic [15:0] req_offset = '0;
  logic [31:0] req_rt_data = '0;
  logic [4:0]  req_rt_idx = '0;

  logic [5:0]  mem_opcode, mem_opcode2;
  logic [31:0] mem_addr, mem_addr2, mem_wdata, mem_wdata2, mem_rdata, mem_rdata2;
  logic        resp_valid, resp_valid2;
  logic [31:0] resp_data, resp_data2;
  logic [4:0]  resp_rt_idx, resp_rt_idx2;
  logic        resp_is_load, resp_is_load2, fault, fault2;

  load_store_unit #(.MEM_DEPTH(33), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_base(req_base), .req_offset(req_offset),
    .req_rt_data(req_rt_data), .req_rt_idx(req_rt_idx),
    .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rt_idx(resp_rt_idx),
    .resp_is_load(resp_is_load), .fault(fault)
  );

  load_store_unit #(.MEM_DEPTH(33), .WAIT_CYCLES(3)) dut_wait (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_opcode(req_opcode), .req_base(req_base), .req_offset(req_offset),
    .req_rt_data(req_rt_data), .req_rt_idx(req_rt_idx),
    .mem_opcode(mem_opcode2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .resp_valid(resp_valid2), .resp_data(resp_data2), .resp_rt_idx(resp_rt_idx2),
    .resp_is_load(resp_is_load2), .fault(fault2)
  );

  // Behavioural data memories: combinational read, store sampled on negedge.
  logic [31:0] mem [0:32];
  int          wcnt [0:32];
  int          act = 0;
  int          lw2_cnt = 0;
  int          addr2_bad = 0;

  assign mem_rdata  = (mem_addr < 32'd33) ? mem[mem_addr[5:0]] : 32'h0;
  assign mem_rdata2 = (mem_addr2 == 32'd0) ? 32'h1234_5678 : 32'h0;

  initial begin
    for (int i = 0; i < 33; i++) begin
      mem[i]  = 32'hA000_0000 + 32'(i);
      wcnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_opcode != OP_NOP) act++;
    if (mem_opcode == OP_SW && mem_addr < 32'd33) begin
      mem[mem_addr[5:0]] = mem_wdata;
      wcnt[mem_addr[5:0]]++;
    end
    if (mem_opcode2 == OP_LW) begin
      lw2_cnt++;
      if (mem_addr2 != 32'd0) addr2_bad++;
    end
  end

  exp_t q[$];
  exp_t q2[$];
  exp_t e1, e2;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=resp_valid required=no response (cycle %0d)", cyc);
      end else begin
        e1 = q.pop_front();
        chk("resp_data", resp_data, e1.data);
        chk("resp_rt_idx", 32'(resp_rt_idx), 32'(e1.rt));
        chk("resp_is_load", 32'(resp_is_load), 32'(e1.is_load));
        chk("fault", 32'(fault), 32'(e1.fault));
        chk("resp_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp2_unexpected actual=resp_valid required=no response (cycle %0d)", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("resp2_data", resp_data2, e2.data);
        chk("resp2_rt_idx", 32'(resp_rt_idx2), 32'(e2.rt));
        chk("resp2_is_load", 32'(resp_is_load2), 32'(e2.is_load));
        chk("fault2", 32'(fault2), 32'(e2.fault));
        chk("resp2_cycle", 32'(cyc), 32'(e2.cyc));
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [31:0] base, input logic [15:0] off,
                      input logic [31:0] wd, input logic [4:0] rt, input logic push,
                      input logic [31:0] ed, input logic ef, output int acc);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    req_opcode  = op;
    req_base    = base;
    req_offset  = off;
    req_rt_data = wd;
    req_rt_idx  = rt;
    req_valid   = 1'b1;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=req_ready low required=high within 50 cycles");
    end
    acc = cyc + 1;
    if (push) begin
      e.data    = ed;
      e.rt      = rt;
      e.is_load = (op == OP_LW);
      e.fault   = ef;
      e.cyc     = ef ? acc : acc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || q2.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(q.size() + q2.size()), 32'd0);
  endtask

  initial begin
    int a0, a1, a2, act0, guard;
    exp_t e;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_opcode", 32'(mem_opcode), 32'(OP_NOP));
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // Reset in the middle of a store access, before the memory's negedge
    send(OP_SW, 32'd5, 16'd0, 32'hCAFE_F00D, 5'd0, 1'b0, 32'd0, 1'b0, a0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_opcode", 32'(mem_opcode), 32'(OP_NOP));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_store_suppressed", mem[5], 32'hA000_0005);
    chk("rst_store_count", 32'(wcnt[5]), 32'd0);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Store then load through a negative offset
    send(OP_SW, 32'd3, 16'd2, 32'hDEAD_BEEF, 5'd1, 1'b1, 32'd0, 1'b0, a0);
    send(OP_LW, 32'd10, 16'hFFFB, 32'd0, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b0, a0);
    // Highest valid word
    send(OP_LW, 32'd30, 16'd2, 32'd0, 5'd2, 1'b1, 32'hA000_0020, 1'b0, a0);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk("store_mem5", mem[5], 32'hDEAD_BEEF);
    chk("store_mem5_count", 32'(wcnt[5]), 32'd1);

    // Faults: one past the end, unsupported opcode, negative wrap
    act0 = act;
    send(OP_LW, 32'd30, 16'd3, 32'd0, 5'd9, 1'b1, 32'd0, 1'b1, a0);
    send(6'b000100, 32'd1, 16'd0, 32'd0, 5'd3, 1'b1, 32'd0, 1'b1, a0);
    send(OP_SW, 32'd2, 16'hFFFD, 32'h5555_5555, 5'd4, 1'b1, 32'd0, 1'b1, a0);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk("fault_no_mem_activity", 32'(act), 32'(act0));

    // Back-to-back stores with req_valid held
    send(OP_SW, 32'd0, 16'd0, 32'h0000_0011, 5'd0, 1'b1, 32'd0, 1'b0, a0);
    send(OP_SW, 32'd1, 16'd0, 32'h0000_0022, 5'd0, 1'b1, 32'd0, 1'b0, a1);
    send(OP_SW, 32'd2, 16'd0, 32'h0000_0033, 5'd0, 1'b1, 32'd0, 1'b0, a2);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk("b2b_spacing_01", 32'(a1 - a0), 32'd3);
    chk("b2b_spacing_12", 32'(a2 - a1), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_store_count", 32'(wcnt[i]), 32'd1);
      chk("b2b_store_data", mem[i], 32'h11 * 32'(i + 1));
    end

    // Wait states on the second instance
    @(negedge clk);
    req_opcode = OP_LW;
    req_base   = 32'd0;
    req_offset = 16'd0;
    req_rt_idx = 5'd4;
    req_valid2 = 1'b1;
    guard = 0;
    while (!req_ready2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a0 = cyc + 1;
    e.data = 32'h1234_5678; e.rt = 5'd4; e.is_load = 1'b1; e.fault = 1'b0; e.cyc = a0 + 4;
    q2.push_back(e);
    @(posedge clk);
    #1;
    chk("wait_ready_low", 32'(req_ready2), 32'd0);
    @(negedge clk);
    req_valid2 = 1'b0;
    drain();
    chk("wait_window_cycles", 32'(lw2_cnt), 32'd4);
    chk("wait_addr_stable", 32'(addr2_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory load/store interface.
- Accepts one LW/SW request per transaction from the execute stage and computes the word address as base + sign-extended offset.
- Range-checks the address, drives the data memory's opcode/addr/Rt port for exactly one access window, then captures load data.
- Returns a one-cycle response (data, destination register, fault) to writeback.

Parameters:
- MEM_DEPTH, 33: number of 32-bit words in data memory; valid word addresses are 0..MEM_DEPTH-1.
- WAIT_CYCLES, 0: extra cycles the access window is held after the first ACCESS cycle (range 0..15).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_opcode  input  6  100011 = LW, 101011 = SW; anything else is unsupported.
- req_base  input  32  base register value (word address).
- req_offset  input  16  signed word offset.
- req_rt_data  input  32  store data (SW).
- req_rt_idx  input  5  destination register index (LW).
- mem_opcode  output  6  opcode to data memory; 000000 (NOP) outside the access window.
- mem_addr  output  32  word address to data memory.
- mem_wdata  output  32  store data to data memory.
- mem_rdata  input  32  combinational read data from data memory.
- resp_valid  output  1  one-cycle response pulse.
- resp_data  output  32  captured load data; 0 for SW and for faults.
- resp_rt_idx  output  5  echoed req_rt_idx.
- resp_is_load  output  1  1 if the response is for an LW.
- fault  output  1  qualified by resp_valid; address out of range or unsupported opcode.

Behaviour:
- Reset values: all outputs 0, mem_opcode = NOP, state = IDLE, wait counter = 0.
- Asynchronous reset: rst forces IDLE and mem_opcode = NOP immediately, with no clock edge needed. Reset mid-ACCESS therefore suppresses a pending store if it is asserted before the memory's negedge.
- Outputs are registered; mem_* are never combinational from req_*.
- Address: addr = req_base + {{16{req_offset[15]}}, req_offset}, 32-bit, wrap-around ignored. The result is out of range when addr >= MEM_DEPTH, compared as unsigned.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On posedge with req_valid, latch the request.
  - If the opcode is unsupported or the address is out of range, go to RESP with fault = 1 and issue no memory opcode.
  - Otherwise go to ACCESS, set mem_opcode/mem_addr/mem_wdata and load wait counter = WAIT_CYCLES.
- ACCESS:
  - Hold mem_* stable for 1 + WAIT_CYCLES full cycles. The memory samples a store on the negedge within the window.
  - While counter != 0, decrement it.
  - When counter == 0, on the posedge: capture mem_rdata into resp_data (LW only), drive mem_opcode to NOP, go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with fault/resp_* valid.
  - Next state IDLE; req_ready returns high the following cycle.
- Latency: request accepted at posedge N gives resp_valid high during cycle N+2+WAIT_CYCLES. A fault path gives resp_valid during cycle N+1.
- Throughput: one transaction per 3+WAIT_CYCLES cycles; no overlap.
- req_valid while not ready is ignored; the requester must hold it.
- SW response: resp_data = 0, resp_is_load = 0.
- LW response: resp_is_load = 1 and resp_rt_idx echoed. An LW to register 0 is still performed; the writeback stage discards it.
- Store window guarantee: exactly one negedge with mem_opcode = SW when WAIT_CYCLES = 0. With WAIT_CYCLES > 0 the repeated writes carry the same data and address, which is harmless.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_LW = 6'b100011, OP_SW = 6'b101011, OP_NOP = 6'b000000.
  - State encoding for IDLE/ACCESS/RESP.
  - The default MEM_DEPTH value, which is also used by the data memory.
- One sub-module is natural: lsu_addr_gen. It is combinational and produces the sign-extended address sum and the out_of_range flag.
- FSM, counter and output registers live in load_store_unit.

Test Plan:
- Reset: assert rst mid-ACCESS of SW addr 5 before the negedge -> mem_opcode = NOP at once, mem[5] unchanged, req_ready = 1 after release.
- Store then load: SW base = 3, offset = 2, data 0xDEADBEEF; then LW base = 10, offset = -5, rt = 7 -> mem[5] = 0xDEADBEEF; LW response resp_valid at N+2, resp_data = 0xDEADBEEF, resp_rt_idx = 7, fault = 0.
- Out of range: LW base = 30, offset = 3 (addr 33, MEM_DEPTH = 33) -> resp_valid at N+1 with fault = 1, mem_opcode stays NOP throughout.
- Unsupported opcode 000100 -> fault = 1 at N+1, no memory activity.
- Wait states: WAIT_CYCLES = 3, LW addr 0 with mem[0] = 0x12345678 -> mem_* stable for 4 cycles, resp_valid at N+5, resp_data = 0x12345678.
- Back-to-back: req_valid held high for 3 SWs to addrs 0/1/2 -> req_ready low during ACCESS/RESP, each store applied exactly once, 3 resp_valid pulses spaced 3 cycles apart.
